// File: rtl/song_sequencer.sv
// Song reader: walks a selected song in an external synchronous note ROM and presents one {note, duration} pair per note_done.
// Optional looping at end of song when SONG_SEQUENCER_LOOP_EN is defined (adds the loop input).
module song_sequencer #(
  parameter int NOTE_W    = 6,
  parameter int DUR_W     = 6,
  parameter int SONG_BITS = 2,
  parameter int IDX_BITS  = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          play,
  input  logic [SONG_BITS-1:0]          song,
  input  logic                          restart,
  input  logic                          note_done,
`ifdef SONG_SEQUENCER_LOOP_EN
  input  logic                          loop,
`endif
  output logic [SONG_BITS+IDX_BITS-1:0] rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]       rom_data,
  output logic [NOTE_W-1:0]             note,
  output logic [DUR_W-1:0]              duration,
  output logic                          new_note,
  output logic [IDX_BITS-1:0]           note_index,
  output logic                          song_done
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, WAIT, DONE} state_t;

  state_t               state, state_d;
  logic [IDX_BITS-1:0]  idx, idx_d;
  logic [SONG_BITS-1:0] song_latched, song_latched_d;
  logic [NOTE_W-1:0]    note_d;
  logic [DUR_W-1:0]     duration_d;
  logic [IDX_BITS-1:0]  note_index_d;
  logic                 new_note_d;
  logic                 song_done_d;
  logic                 loop_pulse, loop_pulse_d;
  logic                 end_hit;
  logic                 loop_on;

  logic [NOTE_W-1:0]    rom_note;
  logic [DUR_W-1:0]     rom_dur;

`ifdef SONG_SEQUENCER_LOOP_EN
  assign loop_on = loop;
`else
  assign loop_on = 1'b0;
`endif

  assign rom_addr = {song_latched, idx};
  assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur  = rom_data[DUR_W-1:0];

  always_comb begin
    state_d        = state;
    idx_d          = idx;
    song_latched_d = song_latched;
    note_d         = note;
    duration_d     = duration;
    note_index_d   = note_index;
    new_note_d     = 1'b0;
    loop_pulse_d   = 1'b0;
    // A loop-wrap song_done is a single-cycle pulse, even while paused.
    song_done_d    = loop_pulse ? 1'b0 : song_done;
    end_hit        = 1'b0;

    if (play) begin
      if (state == IDLE) begin
        song_latched_d = song;
        idx_d          = '0;
        state_d        = FETCH;
      end else if (song != song_latched) begin
        song_latched_d = song;
        idx_d          = '0;
        song_done_d    = 1'b0;
        state_d        = FETCH;
      end else if (restart) begin
        idx_d       = '0;
        song_done_d = 1'b0;
        state_d     = FETCH;
      end else begin
        case (state)
          FETCH: state_d = LOAD;
          LOAD: begin
            if (rom_dur == '0) begin
              end_hit = 1'b1;
            end else begin
              note_d       = rom_note;
              duration_d   = rom_dur;
              note_index_d = idx;
              new_note_d   = 1'b1;
              state_d      = WAIT;
            end
          end
          WAIT: begin
            if (note_done) begin
              if (idx == {IDX_BITS{1'b1}}) begin
                end_hit = 1'b1;
              end else begin
                idx_d   = idx + 1'b1;
                state_d = FETCH;
              end
            end
          end
          default: ;
        endcase
      end

      if (end_hit) begin
        if (loop_on) begin
          idx_d        = '0;
          state_d      = FETCH;
          song_done_d  = 1'b1;
          loop_pulse_d = 1'b1;
        end else begin
          song_done_d = 1'b1;
          state_d     = DONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      song_latched <= '0;
      note         <= '0;
      duration     <= '0;
      note_index   <= '0;
      new_note     <= 1'b0;
      song_done    <= 1'b0;
      loop_pulse   <= 1'b0;
    end else begin
      state        <= state_d;
      idx          <= idx_d;
      song_latched <= song_latched_d;
      note         <= note_d;
      duration     <= duration_d;
      note_index   <= note_index_d;
      new_note     <= new_note_d;
      song_done    <= song_done_d;
      loop_pulse   <= loop_pulse_d;
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a behavioural synchronous note ROM.
module tb_song_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        play;
  logic [1:0]  song;
  logic        restart;
  logic        note_done;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        new_note;
  logic [4:0]  note_index;
  logic        song_done;

  logic [11:0] rom [128];

  int checks = 0;
  int errors = 0;

  song_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .play       (play),
    .song       (song),
    .restart    (restart),
    .note_done  (note_done),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .note       (note),
    .duration   (duration),
    .new_note   (new_note),
    .note_index (note_index),
    .song_done  (song_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  // song 0: {i, i+1}; song 1: {i+1, 3}, end marker at 5; song 2: {12+i, 8+i}; song 3: {33, 5}, end marker at 1
  initial begin
    for (int i = 0; i < 32; i++) begin
      rom[i]      = {6'(i), 6'(i + 1)};
      rom[32 + i] = {6'(i + 1), (i == 5) ? 6'd0 : 6'd3};
      rom[64 + i] = {6'(12 + i), 6'(8 + i)};
      rom[96 + i] = {6'd33, (i == 1) ? 6'd0 : 6'd5};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_note_done;
    note_done = 1'b1;
    tick;
    note_done = 1'b0;
  endtask

  task automatic wait_new_note(input int max, output bit got);
    got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      tick;
      if (new_note) got = 1'b1;
    end
  endtask

  task automatic count_pulses(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick;
      if (new_note) cnt++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; play = 1'b0; song = 2'd0; restart = 1'b0; note_done = 1'b0;
    tick; tick;
    reset = 1'b0;
    checks++;
    if ({rom_addr, note, duration, new_note, note_index, song_done} !== 26'd0) begin
      errors++;
      $display("FAIL reset: rom_addr=%h note=%0d duration=%0d new_note=%0b note_index=%0d song_done=%0b, required all 0",
               rom_addr, note, duration, new_note, note_index, song_done);
    end
    tick;
    checks++;
    if (new_note !== 1'b0 || rom_addr !== 7'h00) begin
      errors++;
      $display("FAIL idle_no_play: new_note=%0b rom_addr=%h, required 0 and 00", new_note, rom_addr);
    end
  endtask

  task automatic test_first_note;
    song = 2'd2; play = 1'b1;
    tick;
    checks++;
    if (rom_addr !== 7'h40 || new_note !== 1'b0) begin
      errors++;
      $display("FAIL first_addr: rom_addr=%h new_note=%0b, required 40 and 0", rom_addr, new_note);
    end
    tick;
    tick;
    checks++;
    if (new_note !== 1'b1 || note !== 6'd12 || duration !== 6'd8 || note_index !== 5'd0) begin
      errors++;
      $display("FAIL first_note: new_note=%0b note=%0d duration=%0d idx=%0d, required 1 12 8 0",
               new_note, note, duration, note_index);
    end
    tick;
    checks++;
    if (new_note !== 1'b0) begin
      errors++;
      $display("FAIL new_note_width: new_note=%0b, required 0", new_note);
    end
  endtask

  task automatic test_second_note;
    int cnt;
    note_done = 1'b1;
    cnt = 0;
    do begin
      tick;
      note_done = 1'b0;
      cnt++;
    end while (!new_note && cnt < 10);
    checks++;
    if (cnt != 3 || note !== 6'd13 || duration !== 6'd9 || note_index !== 5'd1) begin
      errors++;
      $display("FAIL second_note: latency=%0d note=%0d duration=%0d idx=%0d, required 3 13 9 1",
               cnt, note, duration, note_index);
    end
  endtask

  task automatic test_full_song;
    bit got;
    int cnt;
    for (int i = 2; i < 32; i++) begin
      pulse_note_done;
      wait_new_note(6, got);
      checks++;
      if (!got || note_index !== 5'(i) || note !== 6'(12 + i) || duration !== 6'(8 + i)) begin
        errors++;
        $display("FAIL full_song: got=%0b idx=%0d note=%0d duration=%0d, required 1 %0d %0d %0d",
                 got, note_index, note, duration, i, 12 + i, 8 + i);
      end
    end
    pulse_note_done;
    count_pulses(6, cnt);
    checks++;
    if (cnt != 0 || song_done !== 1'b1) begin
      errors++;
      $display("FAIL full_song_end: pulses=%0d song_done=%0b, required 0 and 1", cnt, song_done);
    end
    pulse_note_done;
    count_pulses(6, cnt);
    checks++;
    if (cnt != 0 || song_done !== 1'b1 || note !== 6'd43 || duration !== 6'd39) begin
      errors++;
      $display("FAIL done_ignores: pulses=%0d song_done=%0b note=%0d duration=%0d, required 0 1 43 39",
               cnt, song_done, note, duration);
    end
  endtask

  task automatic test_end_marker;
    bit got;
    int total;
    logic [4:0] last;
    song = 2'd1;
    tick;
    checks++;
    if (song_done !== 1'b0 || rom_addr !== 7'h20) begin
      errors++;
      $display("FAIL song_change_from_done: song_done=%0b rom_addr=%h, required 0 and 20", song_done, rom_addr);
    end
    wait_new_note(4, got);
    total = got ? 1 : 0;
    last = note_index;
    for (int k = 0; k < 5; k++) begin
      pulse_note_done;
      for (int j = 0; j < 6; j++) begin
        tick;
        if (new_note) begin
          total++;
          last = note_index;
        end
      end
    end
    checks++;
    if (total != 5 || last !== 5'd4 || song_done !== 1'b1 || note !== 6'd5 || duration !== 6'd3) begin
      errors++;
      $display("FAIL end_marker: pulses=%0d last_idx=%0d song_done=%0b note=%0d duration=%0d, required 5 4 1 5 3",
               total, last, song_done, note, duration);
    end
  endtask

  task automatic test_pause;
    int cnt;
    restart = 1'b1;
    tick;
    restart = 1'b0;
    checks++;
    if (song_done !== 1'b0 || rom_addr !== 7'h20) begin
      errors++;
      $display("FAIL restart_song1: song_done=%0b rom_addr=%h, required 0 and 20", song_done, rom_addr);
    end
    tick;
    play = 1'b0;
    note_done = 1'b1;
    count_pulses(10, cnt);
    note_done = 1'b0;
    checks++;
    if (cnt != 0 || rom_addr !== 7'h20) begin
      errors++;
      $display("FAIL pause_load: pulses=%0d rom_addr=%h, required 0 and 20", cnt, rom_addr);
    end
    play = 1'b1;
    tick;
    checks++;
    if (new_note !== 1'b1 || note !== 6'd1 || duration !== 6'd3 || note_index !== 5'd0) begin
      errors++;
      $display("FAIL pause_resume: new_note=%0b note=%0d duration=%0d idx=%0d, required 1 1 3 0",
               new_note, note, duration, note_index);
    end
    play = 1'b0;
    pulse_note_done;
    count_pulses(4, cnt);
    play = 1'b1;
    count_pulses(6, cnt);
    checks++;
    if (cnt != 0 || note_index !== 5'd0) begin
      errors++;
      $display("FAIL pause_note_done: pulses=%0d idx=%0d, required 0 and 0", cnt, note_index);
    end
  endtask

  task automatic test_song_change;
    bit got;
    song = 2'd0;
    wait_new_note(6, got);
    checks++;
    if (!got || note !== 6'd0 || duration !== 6'd1 || note_index !== 5'd0) begin
      errors++;
      $display("FAIL song0_first: got=%0b note=%0d duration=%0d idx=%0d, required 1 0 1 0",
               got, note, duration, note_index);
    end
    pulse_note_done;
    wait_new_note(6, got);
    checks++;
    if (!got || note !== 6'd1 || duration !== 6'd2 || note_index !== 5'd1) begin
      errors++;
      $display("FAIL song0_second: got=%0b note=%0d duration=%0d idx=%0d, required 1 1 2 1",
               got, note, duration, note_index);
    end
    song = 2'd3;
    note_done = 1'b1;
    tick;
    note_done = 1'b0;
    checks++;
    if (rom_addr !== 7'h60 || song_done !== 1'b0) begin
      errors++;
      $display("FAIL song_change: rom_addr=%h song_done=%0b, required 60 and 0", rom_addr, song_done);
    end
    wait_new_note(6, got);
    checks++;
    if (!got || note !== 6'd33 || duration !== 6'd5 || note_index !== 5'd0) begin
      errors++;
      $display("FAIL song3_first: got=%0b note=%0d duration=%0d idx=%0d, required 1 33 5 0",
               got, note, duration, note_index);
    end
  endtask

  task automatic test_back_to_back;
    bit got;
    int cnt;
    restart = 1'b1;
    note_done = 1'b1;
    tick;
    restart = 1'b0;
    note_done = 1'b0;
    checks++;
    if (rom_addr !== 7'h60) begin
      errors++;
      $display("FAIL restart_priority: rom_addr=%h, required 60", rom_addr);
    end
    wait_new_note(6, got);
    checks++;
    if (!got || note_index !== 5'd0) begin
      errors++;
      $display("FAIL restart_replay: got=%0b idx=%0d, required 1 0", got, note_index);
    end
    pulse_note_done;
    count_pulses(6, cnt);
    checks++;
    if (cnt != 0 || song_done !== 1'b1) begin
      errors++;
      $display("FAIL song3_end: pulses=%0d song_done=%0b, required 0 and 1", cnt, song_done);
    end
    restart = 1'b1;
    tick;
    restart = 1'b0;
    checks++;
    if (rom_addr !== 7'h60 || song_done !== 1'b0) begin
      errors++;
      $display("FAIL restart_from_done: rom_addr=%h song_done=%0b, required 60 and 0", rom_addr, song_done);
    end
    wait_new_note(6, got);
    checks++;
    if (!got || note !== 6'd33 || duration !== 6'd5 || note_index !== 5'd0) begin
      errors++;
      $display("FAIL restart_first: got=%0b note=%0d duration=%0d idx=%0d, required 1 33 5 0",
               got, note, duration, note_index);
    end
  endtask

  initial begin
    test_reset;
    test_first_note;
    test_second_note;
    test_full_song;
    test_end_marker;
    test_pause;
    test_song_change;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
Parametrised next-generation song reader. Steps through a selectable song stored in an external synchronous note ROM and presents one {note, duration} pair at a time to the note player. The note player requests the next note with note_done. Compared with the previous reader, it generalises song count, song length and field widths, terminates early on an in-ROM end marker, restarts on a song change, and optionally loops.

Parameters:
NOTE_W, 6, width of note field in ROM word
DUR_W, 6, width of duration field in ROM word
SONG_BITS, 2, log2 of number of songs
IDX_BITS, 5, log2 of max notes per song (MAX_NOTES = 2**IDX_BITS)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
play  input  1  1 = run, 0 = pause (freeze all state)
song  input  SONG_BITS  song select; sampled continuously
restart  input  1  one-cycle pulse: restart current song from index 0
note_done  input  1  one-cycle pulse from note player: current note finished
rom_addr  output  SONG_BITS+IDX_BITS  {song_latched, idx} to note ROM
rom_data  input  NOTE_W+DUR_W  ROM word {note, duration}, valid 1 cycle after rom_addr
note  output  NOTE_W  current note (registered)
duration  output  DUR_W  current duration (registered)
new_note  output  1  one-cycle pulse: note/duration just updated
note_index  output  IDX_BITS  index of the note currently presented
song_done  output  1  level: song finished; held until restart, song change or reset

Behaviour:
- Reset (synchronous, active-high): state=IDLE; idx=0; song_latched=0; note, duration, note_index=0; new_note=0; song_done=0.
- State machine: IDLE, FETCH, LOAD, WAIT, DONE.
- rom_addr = {song_latched, idx}, driven from registers.
- IDLE: if play=1, latch song, set idx=0 and go to FETCH.
- FETCH: one cycle to cover the ROM read latency. Go to LOAD.
- LOAD, duration field == 0 (end marker): perform end handling.
- LOAD, otherwise: register note and duration, set note_index=idx, pulse new_note for exactly one cycle, go to WAIT.
- WAIT: on note_done=1 with play=1:
  - if idx == MAX_NOTES-1, perform end handling;
  - else idx = idx+1 and go to FETCH.
- Latency: note_done to new_note is exactly 3 cycles: WAIT→FETCH, FETCH→LOAD, new_note asserted in the LOAD cycle.
- End handling: song_done=1, go to DONE. note and duration keep their last values. No new_note pulse.
- DONE: note_done is ignored. Leave DONE only on restart, a song change or reset.
- play=0: every state, idx and output register holds its value. new_note is forced to 0. note_done and restart are ignored.
  - A new_note due in LOAD is deferred: LOAD is held until play=1.
- Song change: if song != song_latched while play=1 and state != IDLE:
  - latch the new song, set idx=0, clear song_done, go to FETCH next cycle;
  - a note_done in the same cycle is discarded.
- restart=1 with play=1 in any state except IDLE: idx=0, clear song_done, go to FETCH. Restart takes priority over note_done.
- Priority order: reset > play=0 freeze > song change > restart > note_done.
- idx never wraps implicitly. Reaching MAX_NOTES-1 with note_done always goes to end handling.

Optional Feature:
SONG_SEQUENCER_LOOP_EN
- Defined: adds input port loop (1 bit). In end handling with loop=1:
  - idx=0, go to FETCH;
  - song_done is not set;
  - song_done pulses for exactly one cycle, the cycle after end handling.
  - With loop=0, end handling is unchanged.
- Undefined: port absent; behaviour identical to loop=0.

Test Plan:
- Reset, then play=1, song=2, ROM entry 0 = {note 12, dur 8} → rom_addr=0x40; new_note pulse with note=12, duration=8, note_index=0.
- Second note: note_done pulse → new_note exactly 3 cycles later with ROM entry 1, note_index=1.
- Full song: 32 nonzero entries, 32 note_done pulses → 32 new_note pulses; song_done=1 after the last; further note_done gives no new_note.
- End marker: entry 5 has duration=0 → exactly 5 new_note pulses (indices 0–4), then song_done=1.
- Pause: play=0 during LOAD for 10 cycles → no new_note; play=1 → new_note in the next cycle; note_done while paused is ignored.
- Mid-song song 0→3 with a simultaneous note_done, then restart while in DONE → rom_addr=0x60 next cycle, song_done=0, first note of song 3 replayed.
